// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding, stall counter type and
// the packed control word that drives the PC / IF_ID / ID_EX enables.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_e;

    localparam int REG_ZERO = 0;
    localparam int CNT_BITS = 8;

    typedef logic [CNT_BITS-1:0] cnt_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic if_flush;
        logic idex_bubble;
        logic idex_write;
        logic busy;
    } ctrl_t;

    // One control word per pipeline situation.
    localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b1,
                                        idex_bubble: 1'b1, idex_write: 1'b0, busy: 1'b0};
    localparam ctrl_t CTRL_RUN      = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b0,
                                        idex_bubble: 1'b0, idex_write: 1'b1, busy: 1'b0};
    localparam ctrl_t CTRL_FLUSH    = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b1,
                                        idex_bubble: 1'b1, idex_write: 1'b1, busy: 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                        idex_bubble: 1'b1, idex_write: 1'b1, busy: 1'b0};
    localparam ctrl_t CTRL_MUL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                        idex_bubble: 1'b0, idex_write: 1'b0, busy: 1'b0};
    localparam ctrl_t CTRL_MUL_WAIT = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0,
                                        idex_bubble: 1'b0, idex_write: 1'b0, busy: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle: decoder/pipeline-register fields in, stage enables out.
// master = pipeline side that drives the hazard inputs, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] IFID_rs_i;
    logic [REG_AW-1:0] IFID_rt_i;
    logic [REG_AW-1:0] IDEX_rt_i;
    logic              IDEX_MemRead_i;
    logic              branch_taken_i;
    logic              jump_i;
    logic              mul_start_i;

    logic              PC_write_o;
    logic              IF_ID_write_o;
    logic              IF_Flush_o;
    logic              ID_EX_bubble_o;
    logic              ID_EX_write_o;
    logic              busy_o;

    modport master (
        output IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_MemRead_i,
               branch_taken_i, jump_i, mul_start_i,
        input  PC_write_o, IF_ID_write_o, IF_Flush_o, ID_EX_bubble_o,
               ID_EX_write_o, busy_o
    );

    modport slave (
        input  IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_MemRead_i,
               branch_taken_i, jump_i, mul_start_i,
        output PC_write_o, IF_ID_write_o, IF_Flush_o, ID_EX_bubble_o,
               ID_EX_write_o, busy_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// One-cycle update latency; async active-low reset clears to zero.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch / multi-cycle-multiply stall and flush sequencer; Mealy, outputs valid same cycle.
// Stalls by dropping PC/IF_ID (and ID_EX during multiply) enables; HAZ_STATS_EN adds stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam cnt_t MUL_INIT = cnt_t'(MUL_LAT - 1);

    if ((MUL_LAT < 2) || (MUL_LAT > 255) || (CNT_W < 1)) begin : g_bad_param
        $error("pipe_hazard_ctrl: MUL_LAT must be 2..255 and CNT_W at least 1");
    end

    state_e            state_q;
    state_e            state_d;
    cnt_t              cnt_q;
    cnt_t              cnt_d;
    ctrl_t             ctrl;

    logic [REG_AW-1:0] ifid_rs;
    logic [REG_AW-1:0] ifid_rt;
    logic [REG_AW-1:0] idex_rt;
    logic              load_use;
    logic              redirect;

    assign ifid_rs = hz.IFID_rs_i;
    assign ifid_rt = hz.IFID_rt_i;
    assign idex_rt = hz.IDEX_rt_i;

    // A load into r0 never produces a value, so it can never cause a hazard.
    assign load_use = hz.IDEX_MemRead_i
                    && (idex_rt != REG_AW'(REG_ZERO))
                    && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    assign redirect = hz.branch_taken_i || hz.jump_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_RUN;
        if (!rst) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        ctrl = CTRL_FLUSH;
                    end else if (hz.mul_start_i) begin
                        ctrl    = CTRL_MUL_HOLD;
                        state_d = ST_MUL_WAIT;
                        cnt_d   = MUL_INIT;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
                ST_MUL_WAIT: begin
                    // The start cycle counts as the first hold cycle, hence MUL_LAT-1 here.
                    ctrl = CTRL_MUL_WAIT;
                    if (cnt_q == cnt_t'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.PC_write_o     = ctrl.pc_write;
    assign hz.IF_ID_write_o  = ctrl.ifid_write;
    assign hz.IF_Flush_o     = ctrl.if_flush;
    assign hz.ID_EX_bubble_o = ctrl.idex_bubble;
    assign hz.ID_EX_write_o  = ctrl.idex_write;
    assign hz.busy_o         = ctrl.busy;

`ifdef HAZ_STATS_EN
    logic stall_inc;
    logic flush_inc;

    // Reset forces flush/no-write, which must not be counted as pipeline events.
    assign stall_inc = rst && !ctrl.pc_write;
    assign flush_inc = rst && ctrl.if_flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed steps queue expected control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

    // Expected words: {PC_write, IF_ID_write, IF_Flush, bubble, ID_EX_write, busy}
    localparam logic [5:0] X_RST  = 6'b001100;
    localparam logic [5:0] X_RUN  = 6'b110010;
    localparam logic [5:0] X_FLSH = 6'b111110;
    localparam logic [5:0] X_LU   = 6'b000110;
    localparam logic [5:0] X_MUL  = 6'b000000;
    localparam logic [5:0] X_WAIT = 6'b000001;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

`ifdef HAZ_STATS_EN
    logic [1:0] stall_cnt;
    logic [1:0] flush_cnt;

    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LAT(4), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .hz          (hz),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LAT(4), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];
    logic [4:0] st_q[$];
    logic [4:0] st_pending = 5'b0;

    logic [5:0] e_w;
    logic [5:0] act_w;
    logic [4:0] s_w;
    string      n_w;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_w   = exp_q.pop_front();
            n_w   = name_q.pop_front();
            s_w   = st_q.pop_front();
            act_w = {hz.PC_write_o, hz.IF_ID_write_o, hz.IF_Flush_o,
                     hz.ID_EX_bubble_o, hz.ID_EX_write_o, hz.busy_o};
            checks++;
            if (act_w !== e_w) begin
                errors++;
                $display("FAIL %s: ctrl got %b expected %b", n_w, act_w, e_w);
            end
`ifdef HAZ_STATS_EN
            if (s_w[4]) begin
                checks++;
                if ({stall_cnt, flush_cnt} !== s_w[3:0]) begin
                    errors++;
                    $display("FAIL %s_stats: stall/flush got %0d/%0d expected %0d/%0d",
                             n_w, stall_cnt, flush_cnt, s_w[3:2], s_w[1:0]);
                end
            end
`endif
        end
    end

    task automatic step(input logic r, input logic br, input logic jmp, input logic mul,
                        input logic mr, input logic [4:0] idrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [5:0] e, input string nm);
        @(posedge clk);
        #1;
        rst               = r;
        hz.branch_taken_i = br;
        hz.jump_i         = jmp;
        hz.mul_start_i    = mul;
        hz.IDEX_MemRead_i = mr;
        hz.IDEX_rt_i      = idrt;
        hz.IFID_rs_i      = rs;
        hz.IFID_rt_i      = rt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        st_q.push_back(st_pending);
        st_pending = 5'b0;
    endtask

    task automatic idle(input logic [5:0] e, input string nm);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, e, nm);
    endtask

    task automatic mul_go(input logic [5:0] e, input string nm);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, e, nm);
    endtask

    // Arms a stats check on the next step's sample.
    task automatic stat_expect(input logic [1:0] stall, input logic [1:0] flush);
        st_pending = {1'b1, stall, flush};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b0;
        hz.branch_taken_i = 1'b0;
        hz.jump_i         = 1'b0;
        hz.mul_start_i    = 1'b0;
        hz.IDEX_MemRead_i = 1'b0;
        hz.IDEX_rt_i      = '0;
        hz.IFID_rs_i      = '0;
        hz.IFID_rt_i      = '0;

        // Reset with and without a multiply request, then release
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_RST, "rst_idle");
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, X_RST, "rst_mul");
        idle(X_RUN, "post_rst_1");
        idle(X_RUN, "post_rst_2");

        // Load-use detection on rs and rt, r0 exclusion, non-load match
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, X_LU,  "lu_rs");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, X_RUN, "lu_rs_clear");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 5'd0, X_RUN, "lu_rt_zero");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, X_LU,  "lu_rt");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd7, X_RUN, "lu_rt_clear");
        step(1'b1, 1'b0, 1'b0, 1'b0, 0,    5'd9, 5'd9, 5'd9, X_RUN, "no_load");

        // Branch/jump priority over load-use and multiply start
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, X_FLSH, "br_lu");
        idle(X_RUN, "br_lu_after");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_FLSH, "jump");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, X_FLSH, "br_mul");
        idle(X_RUN, "br_mul_after");

        // Multiply: 4 cycles of PC_write low, branch and load-use ignored in MUL_WAIT
        mul_go(X_MUL, "mul_c1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, X_WAIT, "mul_c2_lu");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_WAIT, "mul_c3_br");
        idle(X_WAIT, "mul_c4");
        idle(X_RUN, "mul_release");

        // Held mul_start: ignored in MUL_WAIT, restarts with no gap on release
        mul_go(X_MUL, "b2b_c1");
        repeat (3) mul_go(X_WAIT, "b2b_wait");
        mul_go(X_MUL, "b2b_restart");
        repeat (3) idle(X_WAIT, "b2b_wait2");
        idle(X_RUN, "b2b_release");

        // Reset in the middle of MUL_WAIT discards the count
        mul_go(X_MUL, "t5_c1");
        mul_go(X_WAIT, "t5_c2_mul");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_RST, "t5_rst");
        idle(X_RUN, "t5_rel_1");
        idle(X_RUN, "t5_rel_2");
        idle(X_RUN, "t5_rel_3");
        mul_go(X_MUL, "t5_mul_c1");
        repeat (3) idle(X_WAIT, "t5_mul_wait");
        idle(X_RUN, "t5_mul_release");

`ifdef HAZ_STATS_EN
        // Counters: zero through reset, stall saturates at 3, flush counts branches only
        stat_expect(2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_RST, "st_rst_1");
        stat_expect(2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_RST, "st_rst_2");
        stat_expect(2'd0, 2'd0);
        idle(X_RUN, "st_release");
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, X_LU, "st_lu");
            stat_expect((k > 3) ? 2'd3 : 2'(k), 2'd0);
            idle(X_RUN, "st_lu_after");
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, X_FLSH, "st_br");
        stat_expect(2'd3, 2'd1);
        idle(X_RUN, "st_br_after");
`endif

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
